// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the shared-ALU connection and the
// grant counters of alu_arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int CNTW  = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_c;
    logic             rsp0_zero;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_c;
    logic             rsp1_zero;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_c;
    logic             alu_zero;

    logic [CNTW-1:0]  gnt0_cnt;
    logic [CNTW-1:0]  gnt1_cnt;

    // Requester / ALU side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready, alu_c, alu_zero,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_c, rsp0_zero, rsp1_valid, rsp1_c, rsp1_zero,
        input  alu_a, alu_b, alu_op, gnt0_cnt, gnt1_cnt
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready, alu_c, alu_zero,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_c, rsp0_zero, rsp1_valid, rsp1_c, rsp1_zero,
        output alu_a, alu_b, alu_op, gnt0_cnt, gnt1_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// one-entry response buffer and a saturating grant counter per requester.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int CNTW  = 16
) (
    input  logic          clk,
    input  logic          rstn,
    alu_arbiter_if.slave  bus
);
    localparam logic [OPW-1:0] aluop_nop = {OPW{1'b0}};

    logic             elig0_s;
    logic             elig1_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             last_gnt_r;
    logic             rsp0_valid_r;
    logic [WIDTH-1:0] rsp0_c_r;
    logic             rsp0_zero_r;
    logic             rsp1_valid_r;
    logic [WIDTH-1:0] rsp1_c_r;
    logic             rsp1_zero_r;
    logic [CNTW-1:0]  gnt0_cnt_r;
    logic [CNTW-1:0]  gnt1_cnt_r;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] cnt);
        if (cnt == {CNTW{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Eligibility and round-robin grant; a full, undrained buffer blocks its requester.
    always_comb begin
        elig0_s = bus.req0_valid & (~rsp0_valid_r | bus.rsp0_ready);
        elig1_s = bus.req1_valid & (~rsp1_valid_r | bus.rsp1_ready);
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        if (!rstn) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (elig0_s && (!elig1_s || last_gnt_r)) begin
            gnt0_s = 1'b1;
        end else if (elig1_s) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Route the granted request onto the shared ALU, idle it otherwise.
    always_comb begin
        bus.alu_a  = {WIDTH{1'b0}};
        bus.alu_b  = {WIDTH{1'b0}};
        bus.alu_op = aluop_nop;
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                bus.alu_a  = bus.req0_a;
                bus.alu_b  = bus.req0_b;
                bus.alu_op = bus.req0_op;
            end
            2'b10: begin
                bus.alu_a  = bus.req1_a;
                bus.alu_b  = bus.req1_b;
                bus.alu_op = bus.req1_op;
            end
            default: begin
                bus.alu_a  = {WIDTH{1'b0}};
                bus.alu_b  = {WIDTH{1'b0}};
                bus.alu_op = aluop_nop;
            end
        endcase
    end

    // Remember the last winner; reset value 1 lets requester 0 win first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_gnt_r <= 1'b1;
        end else if (gnt0_s) begin
            last_gnt_r <= 1'b0;
        end else if (gnt1_s) begin
            last_gnt_r <= 1'b1;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    // Response buffer 0: a new load takes priority over a drain in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp0_valid_r <= 1'b0;
            rsp0_c_r     <= {WIDTH{1'b0}};
            rsp0_zero_r  <= 1'b0;
        end else if (gnt0_s) begin
            rsp0_valid_r <= 1'b1;
            rsp0_c_r     <= bus.alu_c;
            rsp0_zero_r  <= bus.alu_zero;
        end else if (bus.rsp0_ready) begin
            rsp0_valid_r <= 1'b0;
        end else begin
            rsp0_valid_r <= rsp0_valid_r;
        end
    end

    // Response buffer 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp1_valid_r <= 1'b0;
            rsp1_c_r     <= {WIDTH{1'b0}};
            rsp1_zero_r  <= 1'b0;
        end else if (gnt1_s) begin
            rsp1_valid_r <= 1'b1;
            rsp1_c_r     <= bus.alu_c;
            rsp1_zero_r  <= bus.alu_zero;
        end else if (bus.rsp1_ready) begin
            rsp1_valid_r <= 1'b0;
        end else begin
            rsp1_valid_r <= rsp1_valid_r;
        end
    end

    // Saturating grant counters for performance monitoring.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt0_cnt_r <= {CNTW{1'b0}};
            gnt1_cnt_r <= {CNTW{1'b0}};
        end else begin
            if (gnt0_s) begin
                gnt0_cnt_r <= sat_inc(gnt0_cnt_r);
            end else begin
                gnt0_cnt_r <= gnt0_cnt_r;
            end
            if (gnt1_s) begin
                gnt1_cnt_r <= sat_inc(gnt1_cnt_r);
            end else begin
                gnt1_cnt_r <= gnt1_cnt_r;
            end
        end
    end

    assign bus.req0_ready = gnt0_s;
    assign bus.req1_ready = gnt1_s;
    assign bus.rsp0_valid = rsp0_valid_r;
    assign bus.rsp0_c     = rsp0_c_r;
    assign bus.rsp0_zero  = rsp0_zero_r;
    assign bus.rsp1_valid = rsp1_valid_r;
    assign bus.rsp1_c     = rsp1_c_r;
    assign bus.rsp1_zero  = rsp1_zero_r;
    assign bus.gnt0_cnt   = gnt0_cnt_r;
    assign bus.gnt1_cnt   = gnt1_cnt_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus stall, async-reset and
// counter-saturation sequences; the shared ALU is a small behavioural model.
module tb_alu_arbiter;
    localparam logic [4:0]  OP_NOP  = 5'd0;
    localparam logic [4:0]  OP_ADD  = 5'd3;
    localparam logic [4:0]  OP_SUB  = 5'd4;
    localparam logic [4:0]  OP_BNE  = 5'd5;
    localparam logic [4:0]  OP_BLT  = 5'd6;
    localparam logic [4:0]  OP_BGE  = 5'd7;
    localparam logic [4:0]  OP_BLTU = 5'd8;
    localparam logic [4:0]  OP_BGEU = 5'd9;
    localparam logic [31:0] M1      = 32'hFFFF_FFFF;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_fail;

    alu_arbiter_if #(.WIDTH(32), .OPW(5), .CNTW(16)) ifc ();
    alu_arbiter_if #(.WIDTH(32), .OPW(5), .CNTW(4))  ifs ();

    alu_arbiter #(.WIDTH(32), .OPW(5), .CNTW(16)) dut (.clk(clk), .rstn(rstn), .bus(ifc));
    alu_arbiter #(.WIDTH(32), .OPW(5), .CNTW(4))  dut_sat (.clk(clk), .rstn(rstn), .bus(ifs));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Branch ops return the condition in C and also flag it as Zero when taken.
    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] op);
        logic [31:0] c;
        logic        z;
        c = 32'd0;
        case (op)
            OP_ADD:  c = a + b;
            OP_SUB:  c = a - b;
            OP_BNE:  c = {31'd0, a != b};
            OP_BLT:  c = {31'd0, $signed(a) < $signed(b)};
            OP_BGE:  c = {31'd0, $signed(a) >= $signed(b)};
            OP_BLTU: c = {31'd0, a < b};
            OP_BGEU: c = {31'd0, a >= b};
            default: c = 32'd0;
        endcase
        z = (op >= OP_BNE && op <= OP_BGEU) ? c[0] : (c == 32'd0);
        return {z, c};
    endfunction

    always_comb begin
        {ifc.alu_zero, ifc.alu_c} = alu_model(ifc.alu_a, ifc.alu_b, ifc.alu_op);
    end

    typedef struct {
        logic        rst;
        logic        v0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [4:0]  op0;
        logic        v1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [4:0]  op1;
        logic        rr0;
        logic        rr1;
        logic        e_rdy0;
        logic        e_rdy1;
        logic [4:0]  e_op;
        logic [31:0] e_alu_a;
        logic        e_v0;
        logic [31:0] e_c0;
        logic        e_z0;
        logic        e_v1;
        logic [31:0] e_c1;
        logic        e_z1;
        logic [15:0] e_n0;
        logic [15:0] e_n1;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.req0_valid = 1'b0; ifc.req0_a = 32'd0; ifc.req0_b = 32'd0; ifc.req0_op = OP_NOP;
        ifc.req1_valid = 1'b0; ifc.req1_a = 32'd0; ifc.req1_b = 32'd0; ifc.req1_op = OP_NOP;
        ifc.rsp0_ready = 1'b0; ifc.rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        // field order: rst | req0 v,a,b,op | req1 v,a,b,op | rsp_ready 0,1 |
        // exp rdy0,rdy1,alu_op,alu_a | exp rsp0 v,c,z | exp rsp1 v,c,z | exp cnt0,cnt1
        vecs[0] = '{1'b1, 1'b1, 32'd5, 32'd7, OP_ADD, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b1, 1'b1,
                    1'b1, 1'b0, OP_ADD, 32'd5, 1'b1, 32'd12, 1'b0, 1'b0, 32'd0, 1'b0, 16'd1, 16'd0};
        vecs[1] = '{1'b0, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b1, 1'b1,
                    1'b0, 1'b0, OP_NOP, 32'd0, 1'b0, 32'd12, 1'b0, 1'b0, 32'd0, 1'b0, 16'd1, 16'd0};
        vecs[2] = '{1'b1, 1'b1, M1, 32'd1, OP_BLTU, 1'b1, 32'd9, 32'd9, OP_BGE, 1'b1, 1'b1,
                    1'b1, 1'b0, OP_BLTU, M1, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd1, 16'd0};
        vecs[3] = '{1'b0, 1'b1, M1, 32'd1, OP_BLTU, 1'b1, 32'd9, 32'd9, OP_BGE, 1'b1, 1'b1,
                    1'b0, 1'b1, OP_BGE, 32'd9, 1'b0, 32'd0, 1'b0, 1'b1, 32'd1, 1'b1, 16'd1, 16'd1};
        vecs[4] = '{1'b0, 1'b1, M1, 32'd1, OP_BLTU, 1'b1, 32'd9, 32'd9, OP_BGE, 1'b1, 1'b1,
                    1'b1, 1'b0, OP_BLTU, M1, 1'b1, 32'd0, 1'b0, 1'b0, 32'd1, 1'b1, 16'd2, 16'd1};
        vecs[5] = '{1'b0, 1'b1, M1, 32'd1, OP_BLTU, 1'b1, 32'd9, 32'd9, OP_BGE, 1'b1, 1'b1,
                    1'b0, 1'b1, OP_BGE, 32'd9, 1'b0, 32'd0, 1'b0, 1'b1, 32'd1, 1'b1, 16'd2, 16'd2};
        vecs[6] = '{1'b1, 1'b1, 32'd10, 32'd3, OP_SUB, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b1, 1'b1,
                    1'b1, 1'b0, OP_SUB, 32'd10, 1'b1, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0, 16'd1, 16'd0};
        vecs[7] = '{1'b0, 1'b1, 32'd4, 32'd4, OP_SUB, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b1, 1'b1,
                    1'b1, 1'b0, OP_SUB, 32'd4, 1'b1, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 16'd2, 16'd0};
        vecs[8] = '{1'b0, 1'b1, 32'd0, 32'd1, OP_SUB, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b1, 1'b1,
                    1'b1, 1'b0, OP_SUB, 32'd0, 1'b1, M1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd3, 16'd0};
        vecs[9] = '{1'b0, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b1, 1'b1,
                    1'b0, 1'b0, OP_NOP, 32'd0, 1'b0, M1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd3, 16'd0};

        // Saturation instance: only requester 0 ever asks, ALU result is don't-care.
        ifs.req0_valid = 1'b0; ifs.req0_a = 32'd0; ifs.req0_b = 32'd0; ifs.req0_op = OP_NOP;
        ifs.req1_valid = 1'b0; ifs.req1_a = 32'd0; ifs.req1_b = 32'd0; ifs.req1_op = OP_NOP;
        ifs.rsp0_ready = 1'b1; ifs.rsp1_ready = 1'b1;
        ifs.alu_c = 32'd0; ifs.alu_zero = 1'b0;

        // Reset state, with a request present to show grants are held off.
        idle_inputs();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        ifc.req0_valid = 1'b1; ifc.req0_a = 32'd5; ifc.req0_op = OP_ADD;
        #2;
        chk("rst_rdy0",   32'(ifc.req0_ready), 32'd0);
        chk("rst_alu_op", 32'(ifc.alu_op), 32'(OP_NOP));
        chk("rst_alu_a",  ifc.alu_a, 32'd0);
        chk("rst_rsp0_v", 32'(ifc.rsp0_valid), 32'd0);
        chk("rst_rsp1_v", 32'(ifc.rsp1_valid), 32'd0);
        chk("rst_cnt0",   32'(ifc.gnt0_cnt), 32'd0);
        step();
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst) do_reset();
            ifc.req0_valid = vecs[i].v0; ifc.req0_a = vecs[i].a0;
            ifc.req0_b = vecs[i].b0; ifc.req0_op = vecs[i].op0;
            ifc.req1_valid = vecs[i].v1; ifc.req1_a = vecs[i].a1;
            ifc.req1_b = vecs[i].b1; ifc.req1_op = vecs[i].op1;
            ifc.rsp0_ready = vecs[i].rr0; ifc.rsp1_ready = vecs[i].rr1;
            #2;
            chk($sformatf("v%0d_rdy0", i),   32'(ifc.req0_ready), 32'(vecs[i].e_rdy0));
            chk($sformatf("v%0d_rdy1", i),   32'(ifc.req1_ready), 32'(vecs[i].e_rdy1));
            chk($sformatf("v%0d_alu_op", i), 32'(ifc.alu_op), 32'(vecs[i].e_op));
            chk($sformatf("v%0d_alu_a", i),  ifc.alu_a, vecs[i].e_alu_a);
            step();
            chk($sformatf("v%0d_rsp0_v", i), 32'(ifc.rsp0_valid), 32'(vecs[i].e_v0));
            chk($sformatf("v%0d_rsp0_c", i), ifc.rsp0_c, vecs[i].e_c0);
            chk($sformatf("v%0d_rsp0_z", i), 32'(ifc.rsp0_zero), 32'(vecs[i].e_z0));
            chk($sformatf("v%0d_rsp1_v", i), 32'(ifc.rsp1_valid), 32'(vecs[i].e_v1));
            chk($sformatf("v%0d_rsp1_c", i), ifc.rsp1_c, vecs[i].e_c1);
            chk($sformatf("v%0d_rsp1_z", i), 32'(ifc.rsp1_zero), 32'(vecs[i].e_z1));
            chk($sformatf("v%0d_cnt0", i),   32'(ifc.gnt0_cnt), 32'(vecs[i].e_n0));
            chk($sformatf("v%0d_cnt1", i),   32'(ifc.gnt1_cnt), 32'(vecs[i].e_n1));
        end

        // Response stall: req0's buffer stays full, req1 keeps being served.
        do_reset();
        ifc.req0_valid = 1'b1; ifc.req0_a = 32'd2; ifc.req0_b = 32'd3; ifc.req0_op = OP_ADD;
        ifc.rsp0_ready = 1'b0; ifc.rsp1_ready = 1'b1;
        #2 chk("stall_first_rdy0", 32'(ifc.req0_ready), 32'd1);
        step();
        chk("stall_first_c0", ifc.rsp0_c, 32'd5);
        ifc.req0_a = 32'd20; ifc.req0_b = 32'd22;
        ifc.req1_valid = 1'b1; ifc.req1_a = 32'd1; ifc.req1_b = 32'd1; ifc.req1_op = OP_ADD;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("stall_rdy0", 32'(ifc.req0_ready), 32'd0);
            chk("stall_rdy1", 32'(ifc.req1_ready), 32'd1);
            step();
            chk("stall_rsp0_v", 32'(ifc.rsp0_valid), 32'd1);
            chk("stall_rsp0_c", ifc.rsp0_c, 32'd5);
            chk("stall_rsp1_c", ifc.rsp1_c, 32'd2);
        end
        ifc.rsp0_ready = 1'b1;
        #2;
        chk("unstall_rdy0", 32'(ifc.req0_ready), 32'd1);
        chk("unstall_rdy1", 32'(ifc.req1_ready), 32'd0);
        step();
        chk("unstall_c0", ifc.rsp0_c, 32'd42);
        chk("unstall_cnt1", 32'(ifc.gnt1_cnt), 32'd3);

        // Asynchronous reset while response 1 is buffered.
        ifc.req0_valid = 1'b0;
        step();
        chk("pre_rst_rsp1_v", 32'(ifc.rsp1_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rsp1_v", 32'(ifc.rsp1_valid), 32'd0);
        chk("async_rsp1_c", ifc.rsp1_c, 32'd0);
        chk("async_rsp0_v", 32'(ifc.rsp0_valid), 32'd0);
        chk("async_rsp0_c", ifc.rsp0_c, 32'd0);
        chk("async_cnt0", 32'(ifc.gnt0_cnt), 32'd0);
        chk("async_cnt1", 32'(ifc.gnt1_cnt), 32'd0);
        chk("async_rdy1", 32'(ifc.req1_ready), 32'd0);
        #1 rstn = 1'b1;
        ifc.req0_valid = 1'b1;
        #1;
        chk("post_rst_rdy0", 32'(ifc.req0_ready), 32'd1);
        chk("post_rst_rdy1", 32'(ifc.req1_ready), 32'd0);
        step();
        chk("post_rst_cnt0", 32'(ifc.gnt0_cnt), 32'd1);
        chk("post_rst_cnt1", 32'(ifc.gnt1_cnt), 32'd0);

        // 4-bit counter saturates at 15 and holds.
        do_reset();
        ifs.req0_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("sat_cnt_%0d", k), 32'(ifs.gnt0_cnt), (k < 15) ? 32'(k) : 32'd15);
        end
        ifs.req0_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
